// File: rtl/arb_pkg.sv
// Shared types, default widths and slice helpers for the packet round-robin input arbiter.
package arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    localparam int unsigned NUM_IN_DEF  = 4;
    localparam int unsigned IDX_W_DEF   = $clog2(NUM_IN_DEF);
    localparam int unsigned DATA_W_DEF  = 256;
    localparam int unsigned TUSER_W_DEF = 128;
    localparam int unsigned CNT_W_DEF   = 32;

    // Index width for n inputs; never collapses to zero bits.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? 32'($clog2(n)) : 32'd1;
    endfunction

    // Low bit of slice idx in a bus of back-to-back w-bit slices.
    function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned w);
        return idx * w;
    endfunction

endpackage

// File: rtl/pkt_rr_input_arbiter_if.sv
// AXI-Stream bundle of N lanes (TDATA/TSTRB/TUSER packed lane after lane) with master/slave views.
interface pkt_rr_input_arbiter_if
    import arb_pkg::*;
#(
    parameter int unsigned N  = 1,
    parameter int unsigned DW = DATA_W_DEF,
    parameter int unsigned UW = TUSER_W_DEF
);

    logic [N*DW-1:0]     TDATA;
    logic [N*(DW/8)-1:0] TSTRB;
    logic [N*UW-1:0]     TUSER;
    logic [N-1:0]        TVALID;
    logic [N-1:0]        TLAST;
    logic [N-1:0]        TREADY;

    modport master (
        output TDATA,
        output TSTRB,
        output TUSER,
        output TVALID,
        output TLAST,
        input  TREADY
    );

    modport slave (
        input  TDATA,
        input  TSTRB,
        input  TUSER,
        input  TVALID,
        input  TLAST,
        output TREADY
    );

endinterface

// File: rtl/rr_priority_select.sv
// Next-grant picker: rotate requests so last_grant+1 sits at bit 0, take the lowest set bit, rotate back.
// With ARB_STRICT_PRIO0_EN defined, a request on input 0 overrides the rotation.
module rr_priority_select
    import arb_pkg::*;
#(
    parameter int unsigned NUM_IN = NUM_IN_DEF,
    parameter int unsigned IDX_W  = IDX_W_DEF
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [IDX_W-1:0]  last_grant,
    output logic              valid,
    output logic [IDX_W-1:0]  idx
);

    logic [2*NUM_IN-1:0] req_dbl;
    logic [NUM_IN-1:0]   req_rot;
    logic                found;
    int unsigned         start;

    always_comb begin
        start   = (32'(last_grant) + 32'd1) % NUM_IN;
        req_dbl = {req, req};
        req_rot = req_dbl[start +: NUM_IN];
        valid   = |req;
        idx     = '0;
        found   = 1'b0;

        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (!found && req_rot[i]) begin
                found = 1'b1;
                idx   = IDX_W'((start + i) % NUM_IN);
            end
        end

`ifdef ARB_STRICT_PRIO0_EN
        // Management/CPU input preempts the rotation at every arbitration.
        if (req[0]) begin
            idx = '0;
        end
`else
`endif
    end

endmodule

// File: rtl/pkt_rr_input_arbiter.sv
// Packet-granular round-robin arbiter muxing NUM_IN AXI-Stream queues onto one lookup datapath.
// Optional build macro ARB_STRICT_PRIO0_EN gives input 0 strict priority over the rotation.
module pkt_rr_input_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned NUM_IN             = NUM_IN_DEF,
    parameter int unsigned C_AXIS_DATA_WIDTH  = DATA_W_DEF,
    parameter int unsigned C_AXIS_TUSER_WIDTH = TUSER_W_DEF,
    parameter int unsigned CNT_WIDTH          = CNT_W_DEF
) (
    input  logic                             AXI_ACLK,
    input  logic                             AXI_RESET,
    pkt_rr_input_arbiter_if.slave            s_axis,
    pkt_rr_input_arbiter_if.master           m_axis,
    input  logic                             clear_counters,
    output logic [idx_width(NUM_IN)-1:0]     grant,
    output logic                             busy,
    output logic [NUM_IN*CNT_WIDTH-1:0]      pkt_count
);

    localparam int unsigned IDX_W = idx_width(NUM_IN);
    localparam int unsigned DW    = C_AXIS_DATA_WIDTH;
    localparam int unsigned SW    = C_AXIS_DATA_WIDTH / 8;
    localparam int unsigned UW    = C_AXIS_TUSER_WIDTH;

    arb_state_e           state_q, state_d;
    logic [IDX_W-1:0]     grant_q, grant_d;
    logic [IDX_W-1:0]     last_grant_q, last_grant_d;
    logic                 busy_q, busy_d;
    logic [CNT_WIDTH-1:0] cnt_q [NUM_IN];
    logic [CNT_WIDTH-1:0] cnt_d [NUM_IN];

    logic                 sel_valid;
    logic [IDX_W-1:0]     sel_idx;

    logic [DW-1:0]        m_tdata_c;
    logic [SW-1:0]        m_tstrb_c;
    logic [UW-1:0]        m_tuser_c;
    logic                 m_tvalid_c;
    logic                 m_tlast_c;
    logic [NUM_IN-1:0]    s_tready_c;
    logic                 pkt_done_c;

    rr_priority_select #(
        .NUM_IN (NUM_IN),
        .IDX_W  (IDX_W)
    ) u_select (
        .req        (s_axis.TVALID),
        .last_grant (last_grant_q),
        .valid      (sel_valid),
        .idx        (sel_idx)
    );

    // Next state, zero-latency datapath mux and counter update.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        m_tdata_c    = '0;
        m_tstrb_c    = '0;
        m_tuser_c    = '0;
        m_tvalid_c   = 1'b0;
        m_tlast_c    = 1'b0;
        s_tready_c   = '0;
        pkt_done_c   = 1'b0;

        case (state_q)
            IDLE: begin
                if (sel_valid) begin
                    grant_d = sel_idx;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                m_tdata_c            = s_axis.TDATA[slice_lo(32'(grant_q), DW) +: DW];
                m_tstrb_c            = s_axis.TSTRB[slice_lo(32'(grant_q), SW) +: SW];
                m_tuser_c            = s_axis.TUSER[slice_lo(32'(grant_q), UW) +: UW];
                m_tvalid_c           = s_axis.TVALID[grant_q];
                m_tlast_c            = s_axis.TLAST[grant_q];
                s_tready_c[grant_q]  = m_axis.TREADY[0];
                pkt_done_c           = m_tvalid_c && m_axis.TREADY[0] && m_tlast_c;

                if (pkt_done_c) begin
                    state_d        = IDLE;
                    cnt_d[grant_q] = cnt_q[grant_q] + CNT_WIDTH'(1);
`ifdef ARB_STRICT_PRIO0_EN
                    // Input 0 wins via priority, so it must not shift the rotation point.
                    if (grant_q != '0) begin
                        last_grant_d = grant_q;
                    end
`else
                    last_grant_d   = grant_q;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Clear overrides a same-cycle increment.
        if (clear_counters) begin
            for (int unsigned i = 0; i < NUM_IN; i++) begin
                cnt_d[i] = '0;
            end
        end

        busy_d = (state_d == BUSY);
    end

    always_ff @(posedge AXI_ACLK) begin
        if (AXI_RESET) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= IDX_W'(NUM_IN - 1);
            busy_q       <= 1'b0;
            for (int unsigned i = 0; i < NUM_IN; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            busy_q       <= busy_d;
            for (int unsigned i = 0; i < NUM_IN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        pkt_count = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            pkt_count[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q[i];
        end
    end

    assign m_axis.TDATA     = m_tdata_c;
    assign m_axis.TSTRB     = m_tstrb_c;
    assign m_axis.TUSER     = m_tuser_c;
    assign m_axis.TVALID[0] = m_tvalid_c;
    assign m_axis.TLAST[0]  = m_tlast_c;
    assign s_axis.TREADY    = s_tready_c;

    assign grant = grant_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_pkt_rr_input_arbiter.sv
// Directed self-checking bench for pkt_rr_input_arbiter (4 inputs, default widths).
module tb_pkt_rr_input_arbiter;

    localparam int unsigned NI = 4;
    localparam int unsigned DW = 256;
    localparam int unsigned UW = 128;
    localparam int unsigned CW = 32;

    logic              clk;
    logic              rst;
    logic              clr;
    logic [1:0]        grant;
    logic              busy;
    logic [NI*CW-1:0]  pkt_count;

    int n_cmp;
    int n_err;

    pkt_rr_input_arbiter_if #(.N(NI), .DW(DW), .UW(UW)) s_if ();
    pkt_rr_input_arbiter_if #(.N(1),  .DW(DW), .UW(UW)) m_if ();

    pkt_rr_input_arbiter #(
        .NUM_IN             (NI),
        .C_AXIS_DATA_WIDTH  (DW),
        .C_AXIS_TUSER_WIDTH (UW),
        .CNT_WIDTH          (CW)
    ) dut (
        .AXI_ACLK       (clk),
        .AXI_RESET      (rst),
        .s_axis         (s_if.slave),
        .m_axis         (m_if.master),
        .clear_counters (clr),
        .grant          (grant),
        .busy           (busy),
        .pkt_count      (pkt_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    function automatic logic [31:0] dw(input int i, input int b);
        return 32'hA000_0000 | (32'(i) << 8) | 32'(b);
    endfunction

    function automatic logic [31:0] cnt(input int i);
        return pkt_count[i*CW +: CW];
    endfunction

    task automatic src(input int i, input logic v, input logic l, input logic [31:0] w);
        s_if.TVALID[i]             = v;
        s_if.TLAST[i]              = l;
        s_if.TDATA[i*DW +: DW]     = DW'(w);
        s_if.TSTRB[i*(DW/8) +: DW/8] = '1;
        s_if.TUSER[i*UW +: UW]     = UW'(w ^ 32'h5555_0000);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int exp_g;
        logic [3:0] exp_rdy;
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b0;
        clr   = 1'b0;
        s_if.TDATA  = '0;
        s_if.TSTRB  = '0;
        s_if.TUSER  = '0;
        s_if.TVALID = '0;
        s_if.TLAST  = '0;
        m_if.TREADY = 1'b1;

        // Reset state
        do_reset();
        settle();
        check("rst_busy",   64'(busy), 64'd0);
        check("rst_grant",  64'(grant), 64'd0);
        check("rst_tready", 64'(s_if.TREADY), 64'd0);
        check("rst_mvalid", 64'(m_if.TVALID), 64'd0);
        check("rst_cnt",    64'(pkt_count[63:0]) | 64'(pkt_count[127:64]), 64'd0);

        // Only input 2 sends a 3-beat packet
        src(2, 1'b1, 1'b0, dw(2, 0));
        settle();
        check("t2_idle_mvalid", 64'(m_if.TVALID), 64'd0);
        check("t2_idle_tready", 64'(s_if.TREADY), 64'd0);
        tick();
        settle();
        check("t2_busy",   64'(busy), 64'd1);
        check("t2_grant",  64'(grant), 64'd2);
        check("t2_b0",     64'(m_if.TDATA[31:0]), 64'(dw(2, 0)));
        check("t2_user",   64'(m_if.TUSER[31:0]), 64'(dw(2, 0) ^ 32'h5555_0000));
        check("t2_tready", 64'(s_if.TREADY), 64'b0100);
        tick();
        src(2, 1'b1, 1'b0, dw(2, 1));
        settle();
        check("t2_b1",    64'(m_if.TDATA[31:0]), 64'(dw(2, 1)));
        check("t2_b1_nl", 64'(m_if.TLAST), 64'd0);
        tick();
        src(2, 1'b1, 1'b1, dw(2, 2));
        settle();
        check("t2_b2",   64'(m_if.TDATA[31:0]), 64'(dw(2, 2)));
        check("t2_last", 64'(m_if.TLAST), 64'd1);
        tick();
        src(2, 1'b0, 1'b0, 32'd0);
        settle();
        check("t2_done_busy", 64'(busy), 64'd0);
        check("t2_hold_grant", 64'(grant), 64'd2);
        check("t2_cnt2", 64'(cnt(2)), 64'd1);
        check("t2_cnt_other", 64'(cnt(0)) | 64'(cnt(1)) | 64'(cnt(3)), 64'd0);

        // All four inputs stream 1-beat packets
        do_reset();
        for (int i = 0; i < 4; i++) src(i, 1'b1, 1'b1, dw(i, 0));
        for (int k = 0; k < 20; k++) begin
            settle();
            check("rr_bubble", 64'(busy), 64'd0);
            check("rr_bubble_v", 64'(m_if.TVALID), 64'd0);
            tick();
            settle();
`ifdef ARB_STRICT_PRIO0_EN
            exp_g = 0;
`else
            exp_g = k % 4;
`endif
            exp_rdy = 4'b0001 << exp_g;
            check("rr_grant", 64'(grant), 64'(exp_g));
            check("rr_data",  64'(m_if.TDATA[31:0]), 64'(dw(exp_g, 0)));
            check("rr_tready", 64'(s_if.TREADY), 64'(exp_rdy));
            tick();
        end
        for (int i = 0; i < 4; i++) src(i, 1'b0, 1'b0, 32'd0);
        settle();
`ifdef ARB_STRICT_PRIO0_EN
        check("rr_cnt0", 64'(cnt(0)), 64'd20);
        check("rr_cnt1", 64'(cnt(1)), 64'd0);
`else
        for (int i = 0; i < 4; i++) check("rr_cnt", 64'(cnt(i)), 64'd5);
`endif

        // Input 1 stalls mid-packet while input 3 waits
        do_reset();
        src(1, 1'b1, 1'b0, dw(1, 0));
        src(3, 1'b1, 1'b1, dw(3, 0));
        tick();
        settle();
        check("st_grant", 64'(grant), 64'd1);
        check("st_tready", 64'(s_if.TREADY), 64'b0010);
        tick();
        src(1, 1'b0, 1'b0, 32'd0);
        for (int c = 0; c < 3; c++) begin
            settle();
            check("st_gap_v", 64'(m_if.TVALID), 64'd0);
            check("st_gap_r3", 64'(s_if.TREADY[3]), 64'd0);
            check("st_gap_grant", 64'(grant), 64'd1);
            tick();
        end
        src(1, 1'b1, 1'b1, dw(1, 1));
        settle();
        check("st_last_v", 64'(m_if.TVALID), 64'd1);
        check("st_last_d", 64'(m_if.TDATA[31:0]), 64'(dw(1, 1)));
        check("st_last_r3", 64'(s_if.TREADY[3]), 64'd0);
        tick();
        src(1, 1'b0, 1'b0, 32'd0);
        settle();
        check("st_idle_r", 64'(s_if.TREADY), 64'd0);
        tick();
        settle();
        check("st_grant3", 64'(grant), 64'd3);
        check("st_data3", 64'(m_if.TDATA[31:0]), 64'(dw(3, 0)));
        tick();
        src(3, 1'b0, 1'b0, 32'd0);
        settle();
        check("st_cnt1", 64'(cnt(1)), 64'd1);
        check("st_cnt3", 64'(cnt(3)), 64'd1);

        // Downstream backpressure: 4 beats over 8 cycles
        src(0, 1'b1, 1'b0, dw(0, 0));
        tick();
        for (int j = 0; j < 8; j++) begin
            src(0, 1'b1, logic'(j / 2 == 3), dw(0, j / 2));
            m_if.TREADY = logic'(j % 2);
            settle();
            check("bp_data", 64'(m_if.TDATA[31:0]), 64'(dw(0, j / 2)));
            check("bp_busy", 64'(busy), 64'd1);
            check("bp_rdy0", 64'(s_if.TREADY[0]), 64'(j % 2));
            tick();
        end
        src(0, 1'b0, 1'b0, 32'd0);
        m_if.TREADY = 1'b1;
        settle();
        check("bp_done", 64'(busy), 64'd0);
        check("bp_cnt0", 64'(cnt(0)), 64'd1);

        // Sole requester re-granted; clear coincides with TLAST
        for (int p = 0; p < 6; p++) begin
            src(0, 1'b1, 1'b1, dw(0, p));
            tick();
            settle();
            check("cl_grant", 64'(grant), 64'd0);
            tick();
        end
        settle();
        check("cl_cnt7", 64'(cnt(0)), 64'd7);
        tick();
        clr = 1'b1;
        settle();
        check("cl_v", 64'(m_if.TVALID), 64'd1);
        tick();
        clr = 1'b0;
        src(0, 1'b0, 1'b0, 32'd0);
        settle();
        check("cl_cnt0", 64'(cnt(0)), 64'd0);
        check("cl_cnt13", 64'(cnt(1)) | 64'(cnt(3)), 64'd0);
        check("cl_busy", 64'(busy), 64'd0);

        // Reset mid-packet on input 2
        src(2, 1'b1, 1'b0, dw(2, 0));
        tick();
        settle();
        check("mr_grant2", 64'(grant), 64'd2);
        tick();
        src(2, 1'b1, 1'b0, dw(2, 1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        check("mr_busy", 64'(busy), 64'd0);
        check("mr_tready", 64'(s_if.TREADY), 64'd0);
        check("mr_mvalid", 64'(m_if.TVALID), 64'd0);
        check("mr_mlast", 64'(m_if.TLAST), 64'd0);
        src(0, 1'b1, 1'b1, dw(0, 9));
        tick();
        settle();
        check("mr_grant0", 64'(grant), 64'd0);
        check("mr_tready0", 64'(s_if.TREADY), 64'b0001);
        tick();
        src(0, 1'b0, 1'b0, 32'd0);
        src(2, 1'b0, 1'b0, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
